// File: rtl/da_shift_accumulator.sv
// Distributed-arithmetic FIR back end: sums the LUT bank per bit cycle and shift-accumulates LSB-first.
// Optional DA_ACC_PIPE_EN adds a register stage between the adder tree and the accumulator.
module da_shift_accumulator #(
    parameter int DATA_W  = 16,
    parameter int LUT_W   = 32,
    parameter int NUM_LUT = 8,
    parameter int ACC_W   = 51
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       bit_valid,
    input  logic [NUM_LUT*LUT_W-1:0]   lut_data,
    output logic signed [ACC_W-1:0]    y,
    output logic                       y_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                  state, state_d;
    logic signed [ACC_W-1:0] acc, acc_d, acc_next, term, psum;
    logic signed [ACC_W-1:0] y_d;
    logic [CNT_W-1:0]        bit_cnt, cnt_d;
    logic                    y_valid_d, overrun_d, last;

    // Accumulator-stage view of the bit cycle (direct or one register later).
    logic signed [ACC_W-1:0] s_psum;
    logic                    s_start, s_valid;

    // NOTE: always_comb uses blocking '=' so each loop iteration sees the previous partial sum.
    always_comb begin
        psum = '0;
        for (int i = 0; i < NUM_LUT; i++)
            psum = psum + ACC_W'($signed(lut_data[i*LUT_W +: LUT_W]));
    end

`ifdef DA_ACC_PIPE_EN
    logic signed [ACC_W-1:0] p_psum;
    logic                    p_start, p_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_psum  <= '0;
            p_start <= 1'b0;
            p_valid <= 1'b0;
        end else begin
            p_psum  <= psum;
            p_start <= start;
            p_valid <= bit_valid;
        end
    end

    assign s_psum  = p_psum;
    assign s_start = p_start;
    assign s_valid = p_valid;
    // A sample's first bit sitting in the pipe register already counts as busy.
    assign busy    = (state == ACCUM) || (p_valid && p_start);
`else
    assign s_psum  = psum;
    assign s_start = start;
    assign s_valid = bit_valid;
    assign busy    = (state == ACCUM);
`endif

    // The last bit is the sign bit of a two's-complement sample, so its weight is negative.
    assign last     = (bit_cnt == CNT_W'(DATA_W - 1));
    assign term     = s_psum << bit_cnt;
    assign acc_next = last ? (acc - term) : (acc + term);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state;
        acc_d     = acc;
        cnt_d     = bit_cnt;
        y_d       = y;
        y_valid_d = 1'b0;
        overrun_d = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid && s_start) begin
                    acc_d   = s_psum;
                    cnt_d   = CNT_W'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (s_valid && s_start) begin
                    acc_d     = s_psum;
                    cnt_d     = CNT_W'(1);
                    overrun_d = 1'b1;
                end else if (s_valid) begin
                    acc_d = acc_next;
                    if (last) begin
                        y_d       = acc_next;
                        y_valid_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            bit_cnt <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_d;
            acc     <= acc_d;
            bit_cnt <= cnt_d;
            y       <= y_d;
            y_valid <= y_valid_d;
            overrun <= overrun_d;
        end
    end

endmodule
